// File: rtl/fifo_arbiter_if.sv
// Client-side request/ack bundle shared by the two FIFO clients and the arbiter.
// master = client side (drives requests), slave = arbiter side (returns acks/data).
interface fifo_arbiter_if #(
  parameter int WIDTH = 7
);
  logic [1:0]         req_rd;
  logic [1:0]         req_wr;
  logic [2*WIDTH-1:0] wr_data;
  logic [1:0]         ack;
  logic [WIDTH-1:0]   rd_data;
  logic               busy;

  modport master (
    output req_rd, req_wr, wr_data,
    input  ack, rd_data, busy
  );

  modport slave (
    input  req_rd, req_wr, wr_data,
    output ack, rd_data, busy
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin sequencer for the shared FT245 FIFO port; read ack 1+STROBE clocks, write ack 3+STROBE clocks.
// Requests are level and held until ack; a granted operation always completes, other requests wait in IDLE.
module fifo_arbiter #(
  parameter int WIDTH          = 7,
  parameter int STROBE_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  fifo_arbiter_if.slave    cli,
  input  logic             fifo_rxf,
  input  logic             fifo_txe,
  output logic             fifo_rd,
  output logic             fifo_wr,
  inout  wire  [WIDTH-1:0] fifo_data
);

  localparam int CMAX = (STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES : RECOVER_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] wdat_q, wdat_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]       ack_q, ack_d;
  logic             busy_q, busy_d;

  logic             elig0, elig1;
  logic             gnt_sel, gnt_is_rd;

  // Flags only matter here; they are consumed solely by the IDLE branch below.
  always_comb begin
    elig0     = (cli.req_rd[0] & ~fifo_rxf) | (cli.req_wr[0] & ~fifo_txe);
    elig1     = (cli.req_rd[1] & ~fifo_rxf) | (cli.req_wr[1] & ~fifo_txe);
    gnt_sel   = (elig0 & elig1) ? ~last_q : elig1;
    gnt_is_rd = cli.req_rd[gnt_sel] & ~fifo_rxf;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    fifo_rd_d = fifo_rd_q;
    fifo_wr_d = fifo_wr_q;
    oe_d      = oe_q;
    wdat_d    = wdat_q;
    rd_data_d = rd_data_q;
    ack_d     = 2'b00;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_d  = gnt_sel;
          last_d = gnt_sel;
          busy_d = 1'b1;
          if (gnt_is_rd) begin
            fifo_rd_d = 1'b0;
            cnt_d     = CW'(STROBE_CYCLES - 1);
            state_d   = RD_STROBE;
          end else begin
            wdat_d  = gnt_sel ? cli.wr_data[2*WIDTH-1:WIDTH] : cli.wr_data[WIDTH-1:0];
            oe_d    = 1'b1;
            state_d = WR_SETUP;
          end
        end
      end
      RD_STROBE: begin
        if (cnt_q == '0) begin
          rd_data_d     = fifo_data;
          fifo_rd_d     = 1'b1;
          ack_d[gnt_q]  = 1'b1;
          cnt_d         = CW'(RECOVER_CYCLES - 1);
          state_d       = RECOVER;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_SETUP: begin
        fifo_wr_d = 1'b0;
        cnt_d     = CW'(STROBE_CYCLES - 1);
        state_d   = WR_STROBE;
      end
      WR_STROBE: begin
        if (cnt_q == '0) begin
          fifo_wr_d = 1'b1;
          state_d   = WR_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_HOLD: begin
        // Data stays on the bus one clock past WR# rising for FIFO hold time.
        oe_d         = 1'b0;
        ack_d[gnt_q] = 1'b1;
        cnt_d        = CW'(RECOVER_CYCLES - 1);
        state_d      = RECOVER;
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      fifo_rd_q <= 1'b1;
      fifo_wr_q <= 1'b1;
      oe_q      <= 1'b0;
      wdat_q    <= '0;
      rd_data_q <= '0;
      ack_q     <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      fifo_rd_q <= fifo_rd_d;
      fifo_wr_q <= fifo_wr_d;
      oe_q      <= oe_d;
      wdat_q    <= wdat_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign fifo_rd     = fifo_rd_q;
  assign fifo_wr     = fifo_wr_q;
  assign fifo_data   = oe_q ? wdat_q : {WIDTH{1'bz}};
  assign cli.ack     = ack_q;
  assign cli.rd_data = rd_data_q;
  assign cli.busy    = busy_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with STROBE_CYCLES=4, RECOVER_CYCLES=2, WIDTH=7.
module tb_fifo_arbiter;

  logic       clk;
  logic       reset;
  logic       fifo_rxf;
  logic       fifo_txe;
  wire        fifo_rd;
  wire        fifo_wr;
  wire  [6:0] fifo_data;
  logic       bus_en;
  logic [6:0] bus_val;
  int         vectors;
  int         miscompares;

  fifo_arbiter_if #(.WIDTH(7)) cif ();

  fifo_arbiter #(
    .WIDTH(7),
    .STROBE_CYCLES(4),
    .RECOVER_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cli(cif),
    .fifo_rxf(fifo_rxf),
    .fifo_txe(fifo_txe),
    .fifo_rd(fifo_rd),
    .fifo_wr(fifo_wr),
    .fifo_data(fifo_data)
  );

  // FIFO-chip side of the bus: drives read data when enabled.
  assign fifo_data = bus_en ? bus_val : 7'bzzzzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus released: a probe pattern from the FIFO side must read back unaltered.
  task automatic chk_released(input string tag);
    logic       sv_en;
    logic [6:0] sv_val;
    sv_en   = bus_en;
    sv_val  = bus_val;
    bus_en  = 1'b1;
    bus_val = 7'h52;
    #1;
    chk(tag, 16'(fifo_data), 16'h52);
    bus_en  = sv_en;
    bus_val = sv_val;
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    fifo_rxf      = 1'b1;
    fifo_txe      = 1'b1;
    bus_en        = 1'b0;
    bus_val       = 7'h00;
    cif.req_rd    = 2'b00;
    cif.req_wr    = 2'b00;
    cif.wr_data   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_fifo_rd", 16'(fifo_rd), 16'd1);
    chk("rst_fifo_wr", 16'(fifo_wr), 16'd1);
    chk("rst_ack", 16'(cif.ack), 16'd0);
    chk("rst_rd_data", 16'(cif.rd_data), 16'd0);
    chk("rst_busy", 16'(cif.busy), 16'd0);
    chk_released("rst_bus_z");
    reset = 1'b0;
    tick();

    // Client 0 read, bus at 41
    bus_en     = 1'b1;
    bus_val    = 7'h41;
    fifo_rxf   = 1'b0;
    cif.req_rd = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) cif.req_rd = 2'b00;
      chk("rd0_strobe", 16'(fifo_rd), (k <= 4) ? 16'd0 : 16'd1);
      chk("rd0_wr_high", 16'(fifo_wr), 16'd1);
      chk("rd0_ack", 16'(cif.ack), (k == 5) ? 16'h1 : 16'h0);
      chk("rd0_busy", 16'(cif.busy), (k <= 6) ? 16'd1 : 16'd0);
      if (k == 5) chk("rd0_data", 16'(cif.rd_data), 16'h41);
    end
    fifo_rxf = 1'b1;
    bus_en   = 1'b0;

    // Client 1 write of 0D
    fifo_txe    = 1'b0;
    cif.wr_data = {7'h0D, 7'h00};
    cif.req_wr  = 2'b10;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) cif.req_wr = 2'b00;
      chk("wr1_strobe", 16'(fifo_wr), (k >= 2 && k <= 5) ? 16'd0 : 16'd1);
      chk("wr1_rd_high", 16'(fifo_rd), 16'd1);
      chk("wr1_ack", 16'(cif.ack), (k == 7) ? 16'h2 : 16'h0);
      chk("wr1_busy", 16'(cif.busy), (k <= 8) ? 16'd1 : 16'd0);
      if (k <= 6) chk("wr1_bus_data", 16'(fifo_data), 16'h0D);
      else        chk_released("wr1_bus_z");
    end

    // Both clients hold writes: grants alternate 0,1,0,1 every 9 clocks
    cif.wr_data = {7'h22, 7'h11};
    cif.req_wr  = 2'b11;
    for (int k = 1; k <= 36; k++) begin
      tick();
      chk("rr_ack", 16'(cif.ack),
          (k % 9 == 7) ? (((k / 9) % 2 == 0) ? 16'h1 : 16'h2) : 16'h0);
      if (k % 9 == 1)
        chk("rr_grant_data", 16'(fifo_data), (((k / 9) % 2 == 0) ? 16'h11 : 16'h22));
    end
    cif.req_wr = 2'b00;

    // Client 0 read and write together: read first, then write
    bus_en      = 1'b1;
    bus_val     = 7'h33;
    fifo_rxf    = 1'b0;
    cif.wr_data = {7'h00, 7'h44};
    cif.req_rd  = 2'b01;
    cif.req_wr  = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) begin
        cif.req_rd = 2'b00;
        bus_en     = 1'b0;
      end
      if (k == 14) cif.req_wr = 2'b00;
      chk("rw_rd", 16'(fifo_rd), (k <= 4) ? 16'd0 : 16'd1);
      chk("rw_wr", 16'(fifo_wr), (k >= 9 && k <= 12) ? 16'd0 : 16'd1);
      chk("rw_ack", 16'(cif.ack), (k == 5 || k == 14) ? 16'h1 : 16'h0);
      if (k == 5) chk("rw_rd_data", 16'(cif.rd_data), 16'h33);
      if (k == 8) chk("rw_wr_data", 16'(fifo_data), 16'h44);
    end

    // RX empty: client 1 read is not granted
    fifo_rxf   = 1'b1;
    cif.req_rd = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rxf_idle_rd", 16'(fifo_rd), 16'd1);
      chk("rxf_idle_busy", 16'(cif.busy), 16'd0);
    end
    cif.req_rd = 2'b00;

    // Reset on the third WR# low clock of a client 1 write
    cif.wr_data = {7'h5A, 7'h66};
    cif.req_wr  = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k >= 2) chk("mid_wr_low", 16'(fifo_wr), 16'd0);
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_wr", 16'(fifo_wr), 16'd1);
    chk("mid_rst_busy", 16'(cif.busy), 16'd0);
    chk("mid_rst_ack", 16'(cif.ack), 16'd0);
    chk("mid_rst_rd_data", 16'(cif.rd_data), 16'd0);
    chk_released("mid_rst_bus_z");
    reset      = 1'b0;
    cif.req_wr = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) cif.req_wr = 2'b00;
      if (k == 1) chk("post_rst_grant0", 16'(fifo_data), 16'h66);
      chk("post_rst_ack", 16'(cif.ack), (k == 7) ? 16'h1 : 16'h0);
    end
    fifo_txe = 1'b1;

    // Request dropped during RD_STROBE still completes, no re-issue
    bus_en     = 1'b1;
    bus_val    = 7'h17;
    fifo_rxf   = 1'b0;
    cif.req_rd = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) cif.req_rd = 2'b00;
      chk("drop_rd", 16'(fifo_rd), (k <= 4) ? 16'd0 : 16'd1);
      chk("drop_ack", 16'(cif.ack), (k == 5) ? 16'h2 : 16'h0);
      chk("drop_busy", 16'(cif.busy), (k <= 6) ? 16'd1 : 16'd0);
      if (k == 5) chk("drop_rd_data", 16'(cif.rd_data), 16'h17);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
